// File: rtl/dec_mul_seq_ctrl_pkg.sv
// Shared definitions for the digit-serial decimal32 multiplier sequencer:
// sizes, exponent bias, FSM state encoding, debug view and a BCD digit check.
package dec_mul_seq_ctrl_pkg;

   localparam int DIGITS = 7;
   localparam int EXP_W  = 8;
   localparam int BIAS   = 101;
   localparam int DIG_W  = 4;
   localparam int MAN_W  = DIGITS * DIG_W;
   localparam int PROD_W = 2 * MAN_W;
   localparam int GRS_W  = 12;
   localparam int SUM_W  = EXP_W + 2;
   localparam int CNT_W  = $clog2(DIGITS);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_MUL  = 3'd2,
      ST_NORM = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Debug view of the sequencer for external checkers.
   typedef struct packed {
      state_t            state;
      logic [CNT_W-1:0]  cnt;
      logic              prod_zero;
   } dbg_t;

   // True when any BCD digit of the mantissa is outside 0..9.
   function automatic logic has_bad_digit(input logic [MAN_W-1:0] man);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (man[i*DIG_W +: DIG_W] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/dec_mul_seq_ctrl_exp.sv
// dec_exp_calc: removes the bias from an unbiased-width exponent sum and
// splits the 10-bit two's complement result into er / carry / underflow.
module dec_exp_calc
   import dec_mul_seq_ctrl_pkg::*;
(
   input  logic [SUM_W-1:0] exp_sum,
   output logic [EXP_W-1:0] er,
   output logic             carry,
   output logic             underflow
);

   logic [SUM_W-1:0] s;

   // Bias subtraction; bit 9 is the sign, bit 8 the overflow past 255.
   always_comb begin
      s         = exp_sum - SUM_W'(BIAS);
      er        = s[EXP_W-1:0];
      underflow = s[SUM_W-1];
      carry     = ~s[SUM_W-1] & s[EXP_W];
   end

endmodule

// File: rtl/dec_mul_seq_ctrl.sv
// dec_mul_seq_ctrl: sequencer for the digit-serial decimal32 multiplier.
// Flow: IDLE -> CLR -> MUL (DIGITS cycles) -> NORM -> DONE -> IDLE.
// Handshakes: a transfer happens on a clk edge where valid and ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE, and the out_*
// registers hold steady for as long as out_valid waits on out_ready.
// Optional feature: DEC_MUL_ZERO_BYPASS_EN sends zero-mantissa operands
// straight from IDLE to DONE with a zero result.
module dec_mul_seq_ctrl
   import dec_mul_seq_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              a_sign,
   input  logic              b_sign,
   input  logic [EXP_W-1:0]  a_exp,
   input  logic [EXP_W-1:0]  b_exp,
   input  logic [MAN_W-1:0]  a_man,
   input  logic [MAN_W-1:0]  b_man,
   output logic              dp_clr,
   output logic              dp_step,
   output logic [DIG_W-1:0]  dp_digit,
   input  logic [PROD_W-1:0] dp_prod,
   output logic [EXP_W-1:0]  nm_er,
   output logic              nm_carry,
   output logic              nm_underflow,
   input  logic [EXP_W:0]    nm_er_res,
   input  logic [MAN_W-1:0]  nm_man,
   input  logic [GRS_W-1:0]  nm_grs,
   input  logic              nm_uf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [EXP_W:0]    out_er,
   output logic [MAN_W-1:0]  out_man,
   output logic [GRS_W-1:0]  out_grs,
   output logic              out_uf,
   output logic              out_inv,
   output dbg_t              dbg
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [MAN_W-1:0] b_shift_q;
   logic [SUM_W-1:0] exp_sum_q;
   logic             sign_q;
   logic             inv_q;
   logic             accept;
   logic             go_bypass;

   assign accept = (state_q == ST_IDLE) && in_valid;

`ifdef DEC_MUL_ZERO_BYPASS_EN
   logic [EXP_W-1:0] in_er;
   logic             in_carry;
   logic             in_uf;

   // Exponent of the incoming operands, needed when the result is loaded at accept.
   dec_exp_calc u_exp_in (
      .exp_sum   (SUM_W'(a_exp) + SUM_W'(b_exp)),
      .er        (in_er),
      .carry     (in_carry),
      .underflow (in_uf)
   );
   assign go_bypass = (a_man == '0) || (b_man == '0);
`else
   assign go_bypass = 1'b0;
`endif

   // Exponent seen by the Normalization stage, from the latched sum.
   dec_exp_calc u_exp (
      .exp_sum   (exp_sum_q),
      .er        (nm_er),
      .carry     (nm_carry),
      .underflow (nm_underflow)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-state strobes.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      dp_clr    = 1'b0;
      dp_step   = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = go_bypass ? ST_DONE : ST_CLR;
         end
         ST_CLR: begin
            dp_clr  = 1'b1;
            state_d = ST_MUL;
         end
         ST_MUL: begin
            dp_step = 1'b1;
            if (cnt_q == CNT_W'(DIGITS - 1)) state_d = ST_NORM;
         end
         ST_NORM: state_d = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Current multiplier digit: LS digit of the shifting copy of b_man.
   always_comb begin
      dp_digit = '0;
      if (state_q == ST_MUL) dp_digit = b_shift_q[DIG_W-1:0];
   end

   // Operand latch at accept, digit counter and multiplier shift during MUL.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         b_shift_q <= '0;
         exp_sum_q <= '0;
         sign_q    <= 1'b0;
         inv_q     <= 1'b0;
      end else if (accept) begin
         b_shift_q <= b_man;
         exp_sum_q <= SUM_W'(a_exp) + SUM_W'(b_exp);
         sign_q    <= a_sign ^ b_sign;
         inv_q     <= has_bad_digit(a_man) | has_bad_digit(b_man);
      end else if (state_q == ST_CLR) begin
         cnt_q <= '0;
      end else if (state_q == ST_MUL) begin
         cnt_q     <= cnt_q + 1'b1;
         b_shift_q <= b_shift_q >> DIG_W;
      end
   end

   // Result registers: loaded in NORM (or at accept on the zero bypass), held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_sign <= 1'b0;
         out_er   <= '0;
         out_man  <= '0;
         out_grs  <= '0;
         out_uf   <= 1'b0;
         out_inv  <= 1'b0;
      end else if (state_q == ST_NORM) begin
         out_sign <= sign_q;
         out_er   <= nm_er_res;
         out_man  <= nm_man;
         out_grs  <= nm_grs;
         out_uf   <= nm_uf;
         out_inv  <= inv_q;
`ifdef DEC_MUL_ZERO_BYPASS_EN
      end else if (accept && go_bypass) begin
         out_sign <= a_sign ^ b_sign;
         out_er   <= {in_carry, in_er};
         out_man  <= '0;
         out_grs  <= '0;
         out_uf   <= 1'b0;
         out_inv  <= has_bad_digit(a_man) | has_bad_digit(b_man);
`endif
      end
   end

   assign dbg.state     = state_q;
   assign dbg.cnt       = cnt_q;
   assign dbg.prod_zero = (dp_prod == '0);

endmodule

// File: tb/tb_dec_mul_seq_ctrl.sv
// Bench for dec_mul_seq_ctrl: table of operand/normalizer/expected records run
// back to back, plus hand-written stall and mid-MUL reset sequences.
module tb_dec_mul_seq_ctrl;
   import dec_mul_seq_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready;
   logic              a_sign, b_sign;
   logic [7:0]        a_exp, b_exp;
   logic [27:0]       a_man, b_man;
   logic              dp_clr, dp_step;
   logic [3:0]        dp_digit;
   logic [55:0]       dp_prod;
   logic [7:0]        nm_er;
   logic              nm_carry, nm_underflow;
   logic [8:0]        nm_er_res;
   logic [27:0]       nm_man;
   logic [11:0]       nm_grs;
   logic              nm_uf;
   logic              out_valid, out_ready;
   logic              out_sign;
   logic [8:0]        out_er;
   logic [27:0]       out_man;
   logic [11:0]       out_grs;
   logic              out_uf, out_inv;
   dbg_t              dbg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        a_sign, b_sign;
      logic [7:0]  a_exp, b_exp;
      logic [27:0] a_man, b_man;
      logic [8:0]  nm_er_res;
      logic [27:0] nm_man;
      logic [11:0] nm_grs;
      logic        nm_uf;
      logic [7:0]  x_er;
      logic        x_carry, x_uf, x_sign, x_inv;
   } vec_t;

   vec_t vecs [10];

   dec_mul_seq_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
      .a_man(a_man), .b_man(b_man), .dp_clr(dp_clr), .dp_step(dp_step),
      .dp_digit(dp_digit), .dp_prod(dp_prod), .nm_er(nm_er), .nm_carry(nm_carry),
      .nm_underflow(nm_underflow), .nm_er_res(nm_er_res), .nm_man(nm_man),
      .nm_grs(nm_grs), .nm_uf(nm_uf), .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_er(out_er), .out_man(out_man), .out_grs(out_grs),
      .out_uf(out_uf), .out_inv(out_inv), .dbg(dbg)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic scramble_operands();
      a_sign = 1'($urandom_range(0, 1));
      b_sign = 1'($urandom_range(0, 1));
      a_exp  = 8'($urandom_range(0, 255));
      b_exp  = 8'($urandom_range(0, 255));
      a_man  = 28'($urandom);
      b_man  = 28'($urandom);
   endtask

   // Drive one operand set and wait through the accepting edge; returns #1 after it.
   task automatic accept_op(input vec_t v);
      @(negedge clk);
      a_sign = v.a_sign; b_sign = v.b_sign;
      a_exp = v.a_exp;   b_exp = v.b_exp;
      a_man = v.a_man;   b_man = v.b_man;
      nm_er_res = v.nm_er_res; nm_man = v.nm_man;
      nm_grs = v.nm_grs;       nm_uf = v.nm_uf;
      in_valid = 1'b1;
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble_operands();
   endtask

   // Full operation: sequence, latency, exponent, result, optional DONE stall.
   task automatic run_op(input int idx, input int stall);
      vec_t        v;
      int          n, clr_cnt, step_cnt, exp_lat, exp_steps;
      logic        bypass;
      logic [3:0]  digs [7];
      logic [27:0] bm;
      logic [8:0]  x_out_er;
      logic [27:0] x_out_man;
      logic [11:0] x_out_grs;
      logic        x_out_uf;
      v = vecs[idx];
      bypass = 1'b0;
`ifdef DEC_MUL_ZERO_BYPASS_EN
      bypass = (v.a_man == 28'd0) || (v.b_man == 28'd0);
`endif
      exp_lat   = bypass ? 1 : 10;
      exp_steps = bypass ? 0 : 7;
      x_out_er  = bypass ? {v.x_carry, v.x_er} : v.nm_er_res;
      x_out_man = bypass ? 28'd0 : v.nm_man;
      x_out_grs = bypass ? 12'd0 : v.nm_grs;
      x_out_uf  = bypass ? 1'b0 : v.nm_uf;
      out_ready = (stall == 0);
      for (int k = 0; k < 7; k++) digs[k] = 4'hF;
      accept_op(v);
      n = 1; clr_cnt = 0; step_cnt = 0;
      while (!out_valid && n < 40) begin
         if (dp_clr) clr_cnt++;
         if (dp_step) begin
            if (step_cnt < 7) digs[step_cnt] = dp_digit;
            step_cnt++;
         end
         if (n == 2) begin
            check($sformatf("v%0d_nm_er", idx), 64'(nm_er), 64'(v.x_er));
            check($sformatf("v%0d_nm_carry", idx), 64'(nm_carry), 64'(v.x_carry));
            check($sformatf("v%0d_nm_underflow", idx), 64'(nm_underflow), 64'(v.x_uf));
            check($sformatf("v%0d_in_ready_busy", idx), 64'(in_ready), 64'd0);
         end
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("v%0d_latency", idx), 64'(n), 64'(exp_lat));
      check($sformatf("v%0d_clr_pulses", idx), 64'(clr_cnt), 64'(bypass ? 0 : 1));
      check($sformatf("v%0d_step_pulses", idx), 64'(step_cnt), 64'(exp_steps));
      if (!bypass) begin
         bm = v.b_man;
         for (int k = 0; k < 7; k++)
            check($sformatf("v%0d_digit%0d", idx, k), 64'(digs[k]), 64'(bm[4*k +: 4]));
      end
      check($sformatf("v%0d_out_sign", idx), 64'(out_sign), 64'(v.x_sign));
      check($sformatf("v%0d_out_er", idx), 64'(out_er), 64'(x_out_er));
      check($sformatf("v%0d_out_man", idx), 64'(out_man), 64'(x_out_man));
      check($sformatf("v%0d_out_grs", idx), 64'(out_grs), 64'(x_out_grs));
      check($sformatf("v%0d_out_uf", idx), 64'(out_uf), 64'(x_out_uf));
      check($sformatf("v%0d_out_inv", idx), 64'(out_inv), 64'(v.x_inv));
      for (int i = 0; i < stall; i++) begin
         in_valid = i[0];
         scramble_operands();
         @(posedge clk); #1;
         check($sformatf("v%0d_stall%0d_valid", idx, i), 64'(out_valid), 64'd1);
         check($sformatf("v%0d_stall%0d_in_ready", idx, i), 64'(in_ready), 64'd0);
         check($sformatf("v%0d_stall%0d_man", idx, i), 64'(out_man), 64'(x_out_man));
         check($sformatf("v%0d_stall%0d_er", idx, i), 64'(out_er), 64'(x_out_er));
         check($sformatf("v%0d_stall%0d_sign", idx, i), 64'(out_sign), 64'(v.x_sign));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check($sformatf("v%0d_after_done_valid", idx), 64'(out_valid), 64'd0);
      check($sformatf("v%0d_after_done_in_ready", idx), 64'(in_ready), 64'd1);
   endtask

   // Stimulus.
   initial begin
      //            as bs  aexp  bexp  a_man         b_man         nm_er_res nm_man        nm_grs   nm_uf x_er   c  u  s  inv
      vecs[0] = '{1'b0,1'b1,8'd101,8'd101,28'h1234567,28'h0000002,9'h065,28'h2469134,12'h000,1'b0,8'h65,1'b0,1'b0,1'b1,1'b0};
      vecs[1] = '{1'b1,1'b1,8'd200,8'd200,28'h0000003,28'h0000003,9'h12B,28'h0000009,12'h000,1'b0,8'h2B,1'b1,1'b0,1'b0,1'b0};
      vecs[2] = '{1'b0,1'b0,8'd10, 8'd20, 28'h0000002,28'h0000003,9'h1B9,28'h0000006,12'h5A0,1'b1,8'hB9,1'b0,1'b1,1'b0,1'b0};
      vecs[3] = '{1'b1,1'b0,8'd101,8'd102,28'h0000001,28'h000000A,9'h066,28'h0000010,12'h000,1'b0,8'h66,1'b0,1'b0,1'b1,1'b1};
      vecs[4] = '{1'b1,1'b0,8'd120,8'd90, 28'h0000000,28'h7654321,9'h06E,28'h0000000,12'h000,1'b0,8'h6D,1'b0,1'b0,1'b1,1'b0};
      vecs[5] = '{1'b0,1'b1,8'd255,8'd255,28'h9999999,28'h9999999,9'h199,28'h9999998,12'h000,1'b0,8'h99,1'b1,1'b0,1'b1,1'b0};
      vecs[6] = '{1'b0,1'b0,8'd50, 8'd51, 28'h0001000,28'h0020000,9'h000,28'h2000000,12'h000,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0};
      vecs[7] = '{1'b1,1'b1,8'd50, 8'd50, 28'h3000000,28'h0000005,9'h1FF,28'h1500000,12'h000,1'b1,8'hFF,1'b0,1'b1,1'b0,1'b0};
      vecs[8] = '{1'b0,1'b0,8'd178,8'd178,28'h5000000,28'h4000000,9'h0FF,28'h2000000,12'h000,1'b0,8'hFF,1'b0,1'b0,1'b0,1'b0};
      vecs[9] = '{1'b0,1'b0,8'd0,  8'd0,  28'h0000001,28'h0000001,9'h19B,28'h0000001,12'h000,1'b1,8'h9B,1'b0,1'b1,1'b0,1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dp_prod = 56'd0;
      nm_er_res = '0; nm_man = '0; nm_grs = '0; nm_uf = 1'b0;
      scramble_operands();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_state", 64'(dbg.state), 64'(ST_IDLE));
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_dp_strobes", 64'({dp_clr, dp_step, dp_digit}), 64'd0);
      check("reset_out_regs", 64'({out_sign, out_er, out_man, out_grs, out_uf, out_inv}), 64'd0);

      for (int i = 0; i < 10; i++) begin
         dp_prod = 56'($urandom);
         run_op(i, (i == 1) ? 5 : 0);
      end

      // Reset in the middle of MUL with cnt = 3.
      accept_op(vecs[0]);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("midmul_state", 64'(dbg.state), 64'(ST_MUL));
      check("midmul_cnt", 64'(dbg.cnt), 64'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_state", 64'(dbg.state), 64'(ST_IDLE));
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_dp_strobes", 64'({dp_clr, dp_step, dp_digit}), 64'd0);
      check("midrst_out_regs", 64'({out_sign, out_er, out_man, out_grs, out_uf, out_inv}), 64'd0);

      run_op(0, 0);
      run_op(3, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
